// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and small decode helpers.
package vga_timing_pkg;

   // Counter width shared by the pixel column and row counters.
   localparam int unsigned CNT_W = 10;
   typedef logic [CNT_W-1:0] cnt_t;

   // Default horizontal timing, in pixels.
   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_FP_DEF     = 16;
   localparam int unsigned H_SYNC_DEF   = 96;
   localparam int unsigned H_BP_DEF     = 48;

   // Default vertical timing, in lines.
   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_FP_DEF     = 10;
   localparam int unsigned V_SYNC_DEF   = 2;
   localparam int unsigned V_BP_DEF     = 33;

   // System clocks per pixel (100 MHz system clock -> 25 MHz pixel rate).
   localparam int unsigned CLK_DIV_DEF  = 4;

   // Derived totals and sync windows for the default mode.
   localparam int unsigned H_TOTAL_DEF      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int unsigned V_TOTAL_DEF      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
   localparam int unsigned H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
   localparam int unsigned H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
   localparam int unsigned V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
   localparam int unsigned V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

   // True when val lies in the inclusive window [lo, hi].
   function automatic logic in_window(input cnt_t val, input cnt_t lo, input cnt_t hi);
      return (val >= lo) && (val <= hi);
   endfunction

endpackage

// File: rtl/vga_timing_gen_pix_clk_div.sv
// Pixel-rate divider: counts system clocks within a pixel and flags the last one.
module pix_clk_div #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_i,
   output logic pix_tick_o
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;

   // Next divider value: wrap after the last clock of the pixel.
   always_comb begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
   end

   // Divider register, cleared asynchronously by reset.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   // Gating with reset keeps the tick low while reset is held, even when CLK_DIV is 1.
   assign pix_tick_o = (div_q == DIV_LAST) && !rst_i;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel/line counters with registered sync, blanking and frame markers.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned H_FP     = H_FP_DEF,
   parameter int unsigned H_SYNC   = H_SYNC_DEF,
   parameter int unsigned H_BP     = H_BP_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned V_FP     = V_FP_DEF,
   parameter int unsigned V_SYNC   = V_SYNC_DEF,
   parameter int unsigned V_BP     = V_BP_DEF,
   parameter int unsigned CLK_DIV  = CLK_DIV_DEF
) (
   input  logic       clk,
   input  logic       reset_button,
   output logic       vga_hsync,
   output logic       vga_vsync,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y,
   output logic       video_on,
   output logic       pix_tick,
   output logic       frame_start
);

   localparam cnt_t H_LAST     = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam cnt_t V_LAST     = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam cnt_t H_VIS      = cnt_t'(H_ACTIVE);
   localparam cnt_t V_VIS      = cnt_t'(V_ACTIVE);
   localparam cnt_t HS_START   = cnt_t'(H_ACTIVE + H_FP);
   localparam cnt_t HS_END     = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam cnt_t VS_START   = cnt_t'(V_ACTIVE + V_FP);
   localparam cnt_t VS_END     = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic tick;
   cnt_t h_q, h_d;
   cnt_t v_q, v_d;
   logic hsync_q, vsync_q, video_on_q, frame_start_q;
   logic frame_start_d;

   pix_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_pix_clk_div (
      .clk        (clk),
      .rst_i      (reset_button),
      .pix_tick_o (tick)
   );

   // Next-state counters: column steps on each pixel tick, row steps when the column wraps.
   always_comb begin
      h_d           = h_q;
      v_d           = v_q;
      frame_start_d = 1'b0;
      if (tick) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
               v_d           = '0;
               frame_start_d = 1'b1;
            end else begin
               v_d = v_q + cnt_t'(1);
            end
         end else begin
            h_d = h_q + cnt_t'(1);
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk or posedge reset_button) begin
      if (reset_button) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   // Decode from next-state counters so sync/blank line up with pix_x/pix_y in the same cycle.
   always_ff @(posedge clk or posedge reset_button) begin
      if (reset_button) begin
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         video_on_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hsync_q       <= ~in_window(h_d, HS_START, HS_END);
         vsync_q       <= ~in_window(v_d, VS_START, VS_END);
         video_on_q    <= (h_d < H_VIS) && (v_d < V_VIS);
         frame_start_q <= frame_start_d;
      end
   end

   assign pix_x       = h_q;
   assign pix_y       = v_q;
   assign vga_hsync   = hsync_q;
   assign vga_vsync   = vsync_q;
   assign video_on    = video_on_q;
   assign pix_tick    = tick;
   assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE / V_FP / V_SYNC / V_BP, defaults 480 / 10 / 2 / 33, vertical equivalents in lines.
REQ-006 Parameter CLK_DIV, default 4, system clocks per pixel (100 MHz -> 25 MHz).
REQ-007 clk  input  1  system clock; one clock domain, all state on its rising edge.
REQ-008 reset_button  input  1  reset, asynchronous, active-high.
REQ-009 vga_hsync  output  1  horizontal sync, active-low.
REQ-010 vga_vsync  output  1  vertical sync, active-low.
REQ-011 pix_x  output  10  current column, 0..H_TOTAL-1.
REQ-012 pix_y  output  10  current row, 0..V_TOTAL-1.
REQ-013 video_on  output  1  high when pix_x < H_ACTIVE and pix_y < V_ACTIVE.
REQ-014 pix_tick  output  1  one-clock pulse marking the last system clock of each pixel.
REQ-015 frame_start  output  1  one-clock pulse when counters wrap to (0,0).

Function
REQ-016 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-017 Divider counts 0..CLK_DIV-1, wrapping. pix_tick is high exactly when the divider equals CLK_DIV-1.
REQ-018 Horizontal counter advances by 1 only on pix_tick and wraps H_TOTAL-1 -> 0.
REQ-019 Vertical counter advances by 1 only on a pix_tick where h = H_TOTAL-1, and wraps V_TOTAL-1 -> 0 on that same tick.
REQ-020 vga_hsync is low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751], high otherwise.
REQ-021 vga_vsync is low for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490,491], high otherwise.
REQ-022 vga_hsync, vga_vsync and video_on are registered and decoded from next-state counters, so they are cycle-aligned with pix_x/pix_y; zero-latency relation, no pipeline skew.
REQ-023 frame_start is a registered pulse. It is high for the single clock in which pix_x/pix_y first read (0,0) after a wrap from (799,524). It is not asserted on reset exit.
REQ-024 Counter widths are 10 bits. No counter passes H_TOTAL-1 / V_TOTAL-1, and no overflow path exists.
REQ-025 Frame period = CLK_DIV*H_TOTAL*V_TOTAL = 1,680,000 clocks at defaults; line period = 3,200 clocks.

Reset
REQ-026 While reset_button is high: divider=0, pix_x=0, pix_y=0, vga_hsync=1, vga_vsync=1, video_on=0, pix_tick=0, frame_start=0.
REQ-027 Reset assertion mid-frame immediately forces the REQ-026 values, independent of clk.
REQ-028 First clock edge after deassertion: video_on=1 at (0,0). The first pix_tick occurs CLK_DIV clocks after deassertion.

Structure
REQ-029 Timing constants (H_*/V_* and derived totals, sync start/end) live in a shared package, vga_timing_pkg, also used by spriteTop and the sprite renderer.
REQ-030 One sub-module, pix_clk_div, generates the divider and pix_tick. Counters and decode stay in vga_timing_gen.
REQ-031 The block drives spriteTop's vga_hsync/vga_vsync directly. pix_x, pix_y and video_on feed the sprite pixel stage, which gates red/green/blue to 0 when video_on=0.

Verification
REQ-032 Reset high 10 ns, then release -> pix_tick pulses every 4 clocks; pix_x steps 0,1,2 at 40 ns pixel intervals.
REQ-033 Run one line -> vga_hsync low for exactly 96 pixels (3,840 ns) starting at pix_x=656; pix_x wraps 799->0 and pix_y increments once.
REQ-034 Run one full frame -> vga_vsync low for exactly 2 lines at pix_y=490..491; frame_start pulses once, 16.8 ms after the first (0,0).
REQ-035 Sample video_on over a frame -> 640*480 = 307,200 active pixels; zero active pixels with pix_x>=640 or pix_y>=480.
REQ-036 Assert reset_button at pix_x=700, pix_y=300 between clock edges -> all outputs take REQ-026 values before the next edge; normal sequence resumes from (0,0) after release.
REQ-037 Parameter override CLK_DIV=2 -> pix_tick every 2 clocks; line period 1,600 clocks.
